data_memory_sync: RTL

//  Parametrised synchronous data memory for the CPU data path; successor to the 8-bit data memory.
//  - Registered read port with a one-cycle valid strobe.
//  - Write-first bypass on same-address read/write.
//  - Clearing is a sequential word-per-cycle sweep after reset or on request, not a one-cycle array clear.
//  - Ready is low while the sweep runs; the control unit must stall on it.

---
 rtl/data_memory_sync_pkg.sv | 17 +
 rtl/data_memory_sync_clear_seq.sv | 65 ++++++
 rtl/data_memory_sync.sv | 84 ++++++++
 3 files changed

// File: rtl/data_memory_sync_pkg.sv
`default_nettype none
// ============================================================================
// data_memory_pkg : shared types and default sizes for data_memory_sync
// Revision: 1.0
// ============================================================================
package data_memory_pkg;

  typedef enum logic {
    MEM_IDLE  = 1'b0,
    MEM_CLEAR = 1'b1
  } mem_state_t;

  localparam int c_DEFAULT_DATA_WIDTH = 8;
  localparam int c_DEFAULT_ADDR_WIDTH = 8;

endpackage
`default_nettype wire

// File: rtl/data_memory_sync_clear_seq.sv
`default_nettype none
// ============================================================================
// mem_clear_sequencer : IDLE/CLEAR state machine driving a word-per-cycle sweep
// Revision: 1.0
// ============================================================================
module mem_clear_sequencer
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH     = c_DEFAULT_ADDR_WIDTH,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clearRequest,
  output logic                  clrActive,
  output logic [ADDR_WIDTH-1:0] clrAddr,
  output logic                  Ready
);

  // One extra bit keeps the terminal compare from wrapping.
  localparam logic [ADDR_WIDTH:0] c_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};

  mem_state_t            r_state;
  logic [ADDR_WIDTH:0]   r_clr_count;
  logic                  r_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= CLEAR_ON_RESET ? MEM_CLEAR : MEM_IDLE;
      r_clr_count <= '0;
      r_ready     <= 1'b0;
    end else begin
      case (r_state)
        MEM_CLEAR: begin
          r_clr_count <= r_clr_count + 1'b1;
          if (r_clr_count == c_LAST) begin
            r_state <= MEM_IDLE;
            r_ready <= 1'b1;
          end
        end
        MEM_IDLE: begin
          // Ready gates the request so the first post-reset cycle cannot start a sweep.
          if (r_ready && clearRequest) begin
            r_state     <= MEM_CLEAR;
            r_clr_count <= '0;
            r_ready     <= 1'b0;
          end else begin
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= MEM_CLEAR;
          r_clr_count <= '0;
          r_ready     <= 1'b0;
        end
      endcase
    end
  end

  assign clrActive = (r_state == MEM_CLEAR);
  assign clrAddr   = r_clr_count[ADDR_WIDTH-1:0];
  assign Ready     = r_ready;

endmodule
`default_nettype wire

// File: rtl/data_memory_sync.sv
`default_nettype none
// ============================================================================
// data_memory_sync : synchronous data memory, registered read, write-first
//                    bypass and a sequential clear sweep gated by Ready
// Revision: 1.0
// ============================================================================
module data_memory_sync
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH     = c_DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH     = c_DEFAULT_ADDR_WIDTH,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  writeEnable,
  input  logic                  readEnable,
  input  logic                  clearRequest,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  ReadValid,
  output logic                  Ready
);

  localparam int c_DEPTH = 1 << ADDR_WIDTH;

  logic                  w_clr_active;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_ready;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_waddr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [DATA_WIDTH-1:0] r_read_data;
  logic                  r_read_valid;

  mem_clear_sequencer #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk          (clk),
    .reset        (reset),
    .clearRequest (clearRequest),
    .clrActive    (w_clr_active),
    .clrAddr      (w_clr_addr),
    .Ready        (w_ready)
  );

  // A clear request wins over any user access issued in the same cycle.
  assign w_wr_accept = w_ready & writeEnable & ~clearRequest;
  assign w_rd_accept = w_ready & readEnable  & ~clearRequest;

  assign w_mem_we    = w_clr_active | w_wr_accept;
  assign w_mem_waddr = w_clr_active ? w_clr_addr : Address;
  assign w_mem_wdata = w_clr_active ? '0 : WriteData;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
    end else begin
      r_read_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_read_data <= w_wr_accept ? WriteData : r_mem[Address];
      end
    end
  end

  assign ReadData  = r_read_data;
  assign ReadValid = r_read_valid;
  assign Ready     = w_ready;

endmodule
`default_nettype wire
